// File: rtl/pixel_unpacker_if.sv
// Handshake bundle for the word-to-pixel gearbox: packed-word input side and
// RGB pixel output side, each with valid/ready.
interface pixel_unpacker_if;
  logic [31:0] in_word;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [23:0] out_pixel;
  logic        out_valid;
  logic        out_last;
  logic        out_partial;
  logic        out_ready;

  modport slave (
    input  in_word, in_valid, in_last, out_ready,
    output in_ready, out_pixel, out_valid, out_last, out_partial
  );

  modport master (
    output in_word, in_valid, in_last, out_ready,
    input  in_ready, out_pixel, out_valid, out_last, out_partial
  );
endinterface

// File: rtl/pixel_unpacker.sv
// Gearbox restoring 24-bit {r,g,b} pixels from packed 32-bit words (3 words = 4 pixels),
// with optional end-of-frame flush that pads a short final pixel.
module pixel_unpacker #(
  parameter bit         LAST_EN  = 1'b1,
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic             clk,
  input  logic             rst_h,
  pixel_unpacker_if.slave  bus
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t      state_q, state_d;
  // Oldest byte sits in [47:40]; bytes at positions >= cnt_q are kept zero.
  logic [47:0] buf_q, buf_d;
  logic [2:0]  cnt_q, cnt_d;

  logic        push, pop;
  logic        in_ready, out_valid, out_last, out_partial;
  logic [23:0] out_pixel;
  logic [1:0]  pop_n;
  logic [1:0]  consumed;
  logic [2:0]  keep;
  logic [47:0] shifted, word_ext;

  always_ff @(posedge clk or posedge rst_h) begin
    if (rst_h) begin
      state_q <= RUN;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (push && bus.in_last && LAST_EN) state_d = FLUSH;
      FLUSH:   if (pop && out_last)                state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_partial = 1'b0;
    out_pixel   = buf_q[47:24];
    pop_n       = 2'd3;
    if (state_q == FLUSH) begin
      out_valid = (cnt_q != 3'd0);
      if (cnt_q >= 3'd3) begin
        out_last = (cnt_q == 3'd3);
      end else begin
        // Short tail: present what is left MSB-first and drain it in one pop.
        out_last    = 1'b1;
        out_partial = 1'b1;
        pop_n       = cnt_q[1:0];
        out_pixel   = {buf_q[47:40], (cnt_q == 3'd2) ? buf_q[39:32] : PAD_BYTE, PAD_BYTE};
      end
    end else begin
      out_valid = (cnt_q >= 3'd3);
      in_ready  = !rst_h && ((cnt_q <= 3'd2) ||
                             ((cnt_q <= 3'd5) && bus.out_ready && out_valid));
    end
  end

  assign push = bus.in_valid & in_ready;
  assign pop  = out_valid & bus.out_ready;

  // Pop shifts the oldest bytes out; a push lands right behind what remains (at most 2 bytes).
  always_comb begin
    consumed = pop ? pop_n : 2'd0;
    keep     = cnt_q - {1'b0, consumed};
    shifted  = buf_q << {consumed, 3'b000};
    word_ext = {bus.in_word, 16'h0000} >> {keep, 3'b000};
    buf_d    = push ? (shifted | word_ext) : shifted;
    cnt_d    = push ? (keep + 3'd4) : keep;
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_pixel   = out_pixel;
  assign bus.out_last    = LAST_EN ? out_last : 1'b0;
  assign bus.out_partial = LAST_EN ? out_partial : 1'b0;

endmodule

// File: tb/tb_pixel_unpacker.sv
// Bench for pixel_unpacker: byte-queue reference model checked every cycle on the
// LAST_EN=1 instance, plus directed literal checks on both instances.
module tb_pixel_unpacker;

  logic clk = 1'b0;
  logic rst_h;
  always #5 clk = ~clk;

  pixel_unpacker_if ifa();
  pixel_unpacker_if ifb();

  pixel_unpacker #(.LAST_EN(1'b1), .PAD_BYTE(8'h00)) dut_a (.clk(clk), .rst_h(rst_h), .bus(ifa));
  pixel_unpacker #(.LAST_EN(1'b0), .PAD_BYTE(8'h00)) dut_b (.clk(clk), .rst_h(rst_h), .bus(ifb));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the frame as a plain byte queue
  logic [7:0]  q[$];
  bit          flushing = 0;
  int          cyc = 0;
  int          stall_cnt = 0;
  logic [23:0] log_px[$];
  bit          log_last[$];
  bit          log_part[$];
  int          log_cyc[$];

  always @(negedge clk) begin : model_cmp
    logic        ev, er, el, ep;
    logic [23:0] epx;
    int          sz, n;
    cyc++;
    if (rst_h) begin
      q.delete();
      flushing = 0;
      chk("rst_out_valid", ifa.out_valid, 0);
      chk("rst_in_ready", ifa.in_ready, 0);
      chk("rst_out_pixel", ifa.out_pixel, 0);
      chk("rst_out_last", ifa.out_last, 0);
      chk("rst_out_partial", ifa.out_partial, 0);
    end else begin
      sz  = q.size();
      ev  = flushing ? (sz > 0) : (sz >= 3);
      epx = {(sz > 0) ? q[0] : 8'h00, (sz > 1) ? q[1] : 8'h00, (sz > 2) ? q[2] : 8'h00};
      el  = flushing && (sz <= 3);
      ep  = flushing && (sz < 3);
      er  = !flushing && ((sz <= 2) || ((sz <= 5) && ifa.out_ready && ev));
      chk("out_valid", ifa.out_valid, ev);
      chk("in_ready", ifa.in_ready, er);
      if (ev) begin
        chk("out_pixel", ifa.out_pixel, epx);
        chk("out_last", ifa.out_last, el);
        chk("out_partial", ifa.out_partial, ep);
      end
      if (ifa.in_valid && !er) stall_cnt++;
      if (ev && ifa.out_ready) begin
        log_px.push_back(ifa.out_pixel);
        log_last.push_back(ifa.out_last);
        log_part.push_back(ifa.out_partial);
        log_cyc.push_back(cyc);
        n = (sz >= 3) ? 3 : sz;
        repeat (n) void'(q.pop_front());
        if (el) flushing = 0;
      end
      if (ifa.in_valid && er) begin
        q.push_back(ifa.in_word[31:24]);
        q.push_back(ifa.in_word[23:16]);
        q.push_back(ifa.in_word[15:8]);
        q.push_back(ifa.in_word[7:0]);
        if (ifa.in_last) flushing = 1;
      end
    end
  end

  task automatic clear_log();
    log_px.delete(); log_last.delete(); log_part.delete(); log_cyc.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_a(input logic [31:0] w, input logic last);
    int n = 0;
    ifa.in_word = w; ifa.in_valid = 1'b1; ifa.in_last = last;
    @(negedge clk);
    while (!ifa.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!ifa.in_ready) chk("send_timeout", ifa.in_ready, 1);
    @(posedge clk); #1;
    ifa.in_valid = 1'b0; ifa.in_last = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_h = 1'b1;
    #1;
    chk("async_rst_out_valid", ifa.out_valid, 0);
    chk("async_rst_in_ready", ifa.in_ready, 0);
    @(posedge clk); #1;
    rst_h = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w;
    logic [23:0] px;
    rst_h = 1'b1;
    ifa.in_word = '0; ifa.in_valid = 1'b0; ifa.in_last = 1'b0; ifa.out_ready = 1'b0;
    ifb.in_word = '0; ifb.in_valid = 1'b0; ifb.in_last = 1'b0; ifb.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_h = 1'b0;
    #1;
    chk("post_rst_in_ready", ifa.in_ready, 1);
    chk("post_rst_out_valid", ifa.out_valid, 0);

    // Nominal three-word frame
    ifa.out_ready = 1'b1;
    clear_log();
    send_a(32'hdeadbeef, 1'b0);
    send_a(32'h01234567, 1'b0);
    send_a(32'h89abcdef, 1'b1);
    idle(6);
    chk("nom_count", log_px.size(), 4);
    if (log_px.size() == 4) begin
      chk("nom_px0", log_px[0], 24'hdeadbe);
      chk("nom_px1", log_px[1], 24'hef0123);
      chk("nom_px2", log_px[2], 24'h456789);
      chk("nom_px3", log_px[3], 24'habcdef);
      for (int i = 0; i < 4; i++) begin
        chk("nom_last", log_last[i], (i == 3));
        chk("nom_partial", log_part[i], 0);
      end
    end

    // Short frame: one word, padded tail
    do_reset();
    clear_log();
    send_a(32'hdeadbeef, 1'b1);
    chk("short_ready_c1", ifa.in_ready, 0);
    @(posedge clk); #1;
    chk("short_ready_c2", ifa.in_ready, 0);
    chk("short_tail_px", ifa.out_pixel, 24'hef0000);
    @(posedge clk); #1;
    chk("short_ready_c3", ifa.in_ready, 1);
    chk("short_valid_c3", ifa.out_valid, 0);
    chk("short_count", log_px.size(), 2);
    if (log_px.size() == 2) begin
      chk("short_px0", log_px[0], 24'hdeadbe);
      chk("short_last0", log_last[0], 0);
      chk("short_px1", log_px[1], 24'hef0000);
      chk("short_last1", log_last[1], 1);
      chk("short_part1", log_part[1], 1);
    end

    // Backpressure with a pending second word
    do_reset();
    clear_log();
    ifa.out_ready = 1'b0;
    send_a(32'hdeadbeef, 1'b0);
    ifa.in_word = 32'h01234567; ifa.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", ifa.in_ready, 0);
      chk("bp_hold_px", ifa.out_pixel, 24'hdeadbe);
    end
    @(posedge clk); #1;
    ifa.out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", ifa.in_ready, 1);
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    ifa.out_ready = 1'b0;
    chk("bp_after_px", ifa.out_pixel, 24'hef0123);
    chk("bp_after_valid", ifa.out_valid, 1);
    chk("bp_pop_count", log_px.size(), 1);
    do_reset();

    // Throughput: 12 back-to-back words, 48 bytes 0..47
    ifa.out_ready = 1'b1;
    clear_log();
    stall_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      w = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
      send_a(w, (k == 11));
    end
    idle(8);
    chk("tp_count", log_px.size(), 16);
    chk("tp_stalls", stall_cnt, 3);
    if (log_px.size() == 16) begin
      chk("tp_consecutive", log_cyc[15] - log_cyc[0], 15);
      for (int p = 0; p < 16; p++) begin
        px = {8'(3*p), 8'(3*p+1), 8'(3*p+2)};
        chk("tp_px", log_px[p], px);
        chk("tp_last", log_last[p], (p == 15));
      end
    end

    // Reset mid-frame with two bytes buffered
    do_reset();
    ifa.out_ready = 1'b1;
    send_a(32'hdeadbeef, 1'b0);
    send_a(32'h01234567, 1'b0);
    do_reset();
    clear_log();
    send_a(32'h01234567, 1'b0);
    idle(3);
    chk("rst_mid_count", log_px.size(), 1);
    if (log_px.size() == 1) chk("rst_mid_px", log_px[0], 24'h012345);
    do_reset();

    // LAST_EN=0 instance: in_last ignored, trailing byte retained
    ifb.out_ready = 1'b1;
    ifb.in_word = 32'hdeadbeef; ifb.in_valid = 1'b1; ifb.in_last = 1'b1;
    #1;
    chk("b_in_ready", ifb.in_ready, 1);
    @(posedge clk); #1;
    ifb.in_valid = 1'b0; ifb.in_last = 1'b0;
    chk("b_valid0", ifb.out_valid, 1);
    chk("b_px0", ifb.out_pixel, 24'hdeadbe);
    chk("b_last0", ifb.out_last, 0);
    @(posedge clk); #1;
    chk("b_valid1", ifb.out_valid, 0);
    chk("b_ready1", ifb.in_ready, 1);
    chk("b_last1", ifb.out_last, 0);
    idle(3);
    chk("b_valid_idle", ifb.out_valid, 0);
    ifb.in_word = 32'h01234567; ifb.in_valid = 1'b1;
    @(posedge clk); #1;
    ifb.in_valid = 1'b0;
    chk("b_valid2", ifb.out_valid, 1);
    chk("b_px2", ifb.out_pixel, 24'hef0123);
    chk("b_partial2", ifb.out_partial, 0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
